// File: rtl/apu_i2s_tx.sv
// apu_i2s_tx: serializes one 16-bit mono sample per frame as an I2S stereo word
// (same value on left and right), with BCLK derived from clk_i by BCLK_DIV.
module apu_i2s_tx #(
   parameter int BCLK_DIV    = 4,
   parameter bit UNSIGNED_IN = 1
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [15:0] sample_i,
   input  logic        enable_i,
   output logic        bclk_o,
   output logic        lrclk_o,
   output logic        sdata_o,
   output logic        frame_o,
   output logic        busy_o
);
   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
   localparam logic [7:0] DIV_LAST = 8'(BCLK_DIV - 1);
   state_t      state_q, state_d;
   logic [7:0]  div_q, div_d;
   logic [4:0]  bit_q, bit_d;
   logic [31:0] sh_q, sh_d;
   logic        bclk_q, bclk_d, lr_q, lr_d, sd_q, sd_d, fr_q, fr_d;
   logic        tick, fall, wrap, go_idle;
   logic [15:0] s;
   assign s       = UNSIGNED_IN ? {~sample_i[15], sample_i[14:0]} : sample_i;
   assign tick    = div_q == DIV_LAST;
   assign fall    = tick && bclk_q;
   assign wrap    = fall && bit_q == 5'd31;
   // A drain ends on the edge that would start the next frame, unless re-enabled.
   assign go_idle = wrap && state_q == DRAIN && !enable_i;
   always_comb begin
      state_d = state_q;
      div_d   = div_q;
      bit_d   = bit_q;
      sh_d    = sh_q;
      bclk_d  = bclk_q;
      lr_d    = lr_q;
      sd_d    = sd_q;
      fr_d    = 1'b0;
      if (state_q == IDLE) begin
         state_d = enable_i ? RUN : IDLE;
      end else if (go_idle) begin
         state_d = IDLE;
         div_d   = 8'd0;
         bit_d   = 5'd31;
         sh_d    = 32'd0;
         bclk_d  = 1'b0;
         lr_d    = 1'b0;
         sd_d    = 1'b0;
      end else begin
         state_d = enable_i ? RUN : DRAIN;
         div_d   = tick ? 8'd0 : div_q + 8'd1;
         bclk_d  = bclk_q ^ tick;
         if (fall) begin
            bit_d = bit_q + 5'd1;
            lr_d  = bit_d >= 5'd15 && bit_d <= 5'd30;
            sh_d  = wrap ? {s, s} : {sh_q[30:0], 1'b0};
            sd_d  = wrap ? s[15] : sh_q[30];
            fr_d  = wrap;
         end
      end
   end
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         div_q   <= 8'd0;
         bit_q   <= 5'd31;
         sh_q    <= 32'd0;
         bclk_q  <= 1'b0;
         lr_q    <= 1'b0;
         sd_q    <= 1'b0;
         fr_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         bit_q   <= bit_d;
         sh_q    <= sh_d;
         bclk_q  <= bclk_d;
         lr_q    <= lr_d;
         sd_q    <= sd_d;
         fr_q    <= fr_d;
      end
   end
   assign bclk_o  = bclk_q;
   assign lrclk_o = lr_q;
   assign sdata_o = sd_q;
   assign frame_o = fr_q;
   assign busy_o  = state_q != IDLE;
endmodule

// File: tb/tb_apu_i2s_tx.sv
// tb_apu_i2s_tx: randomized and directed checks of apu_i2s_tx against a timeline model.
module tb_apu_i2s_tx;
   localparam int D = 2;
   logic        clk = 1'b0, rst = 1'b1, enable = 1'b0;
   logic [15:0] sample = 16'h0;
   logic        bclk_o, lrclk_o, sdata_o, frame_o, busy_o;
   logic        bclk1, lr1, sd1, fr1, busy1;
   int          checks = 0, failures = 0;
   bit          mon = 1'b0;
   always #5 clk = ~clk;
   apu_i2s_tx #(.BCLK_DIV(D), .UNSIGNED_IN(1)) u0 (
      .clk_i(clk), .rst_i(rst), .sample_i(sample), .enable_i(enable),
      .bclk_o(bclk_o), .lrclk_o(lrclk_o), .sdata_o(sdata_o), .frame_o(frame_o), .busy_o(busy_o));
   apu_i2s_tx #(.BCLK_DIV(D), .UNSIGNED_IN(0)) u1 (
      .clk_i(clk), .rst_i(rst), .sample_i(sample), .enable_i(enable),
      .bclk_o(bclk1), .lrclk_o(lr1), .sdata_o(sd1), .frame_o(fr1), .busy_o(busy1));

   // Timeline model: r counts clk edges since the start edge; frames start every 64*D
   // edges beginning at edge 2*D, and bit n of a frame occupies 2*D edges.
   int          m_r = 0, m_p, m_n;
   bit          m_run = 1'b0, m_b, m_lr, m_sd, m_sdr, m_fr;
   logic [15:0] m_cu = 16'h0, m_cs = 16'h0;
   logic [9:0]  exp_v = 10'h0;
   always @(posedge clk) begin
      if (rst) m_run = 1'b0;
      else if (!m_run) begin
         if (enable) begin m_run = 1'b1; m_r = 0; end
      end else begin
         m_r++;
         if (m_r >= 2*D && (m_r - 2*D) % (64*D) == 0) begin
            if (!enable) m_run = 1'b0;
            else begin m_cu = sample ^ 16'h8000; m_cs = sample; end
         end
      end
      m_b = ((m_r / D) % 2) == 1;
      m_lr = 1'b0; m_sd = 1'b0; m_sdr = 1'b0; m_fr = 1'b0;
      if (m_r >= 2*D) begin
         m_p  = m_r - 2*D;
         m_n  = (m_p / (2*D)) % 32;
         m_lr = m_n >= 15 && m_n <= 30;
         m_sd = m_cu[15 - m_n % 16];
         m_sdr = m_cs[15 - m_n % 16];
         m_fr = (m_p % (64*D)) == 0;
      end
      exp_v = m_run ? {m_b, m_lr, m_sd, m_fr, 1'b1, m_b, m_lr, m_sdr, m_fr, 1'b1} : 10'h0;
   end

   always @(negedge clk) if (mon) begin
      checks++;
      if ({bclk_o, lrclk_o, sdata_o, frame_o, busy_o, bclk1, lr1, sd1, fr1, busy1} !== exp_v) begin
         failures++;
         $display("FAIL model t=%0t got=%b exp=%b", $time,
                  {bclk_o, lrclk_o, sdata_o, frame_o, busy_o, bclk1, lr1, sd1, fr1, busy1}, exp_v);
      end
   end

   // Waits for frame_o, then records one sdata bit per BCLK from both DUTs;
   // sample is changed to nv during bit slot cb.
   task automatic cap(input int cb, input logic [15:0] nv, output logic [31:0] w0,
                      output logic [31:0] w1, output bit ok);
      int k = 0;
      while (frame_o !== 1'b1 && k < 300) begin @(negedge clk); k++; end
      ok = frame_o === 1'b1;
      for (int n = 0; n < 32; n++) begin
         w0[31-n] = sdata_o;
         w1[31-n] = sd1;
         if (n == cb) sample = nv;
         repeat (2*D) @(negedge clk);
      end
   endtask

   task automatic test_reset;
      rst = 1'b1; enable = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({bclk_o, lrclk_o, sdata_o, frame_o, busy_o} !== 5'b0) begin
         failures++; $display("FAIL reset_u0 got=%b exp=00000", {bclk_o, lrclk_o, sdata_o, frame_o, busy_o});
      end
      checks++;
      if ({bclk1, lr1, sd1, fr1, busy1} !== 5'b0) begin
         failures++; $display("FAIL reset_u1 got=%b exp=00000", {bclk1, lr1, sd1, fr1, busy1});
      end
      enable = 1'b0; rst = 1'b0;
      @(negedge clk);
      mon = 1'b1;
      repeat (4) @(negedge clk);
      checks++;
      if (busy_o !== 1'b0) begin failures++; $display("FAIL idle_hold busy=%b exp=0", busy_o); end
   endtask

   task automatic test_basic;
      int k = 0; logic [31:0] w0, w1; bit ok;
      sample = 16'hC000; enable = 1'b1;
      do begin @(negedge clk); k++; end while (frame_o !== 1'b1 && k < 50);
      checks++;
      if (k != 2*D + 1) begin failures++; $display("FAIL first_frame negedges=%0d exp=%0d", k, 2*D + 1); end
      cap(31, 16'hFFFF, w0, w1, ok);
      checks++;
      if (!ok || w0 !== 32'h40004000) begin failures++; $display("FAIL basic_word got=%h exp=40004000", w0); end
      checks++;
      if (frame_o !== 1'b1) begin failures++; $display("FAIL frame_period frame=%b exp=1", frame_o); end
   endtask

   task automatic test_bounds;
      logic [15:0] v [7]; logic [31:0] w0, w1, e0, e1; logic [15:0] nxt; bit ok;
      v[0] = 16'hFFFF; v[1] = 16'h0000; v[2] = 16'h1234;
      for (int i = 3; i < 7; i++) v[i] = 16'($urandom);
      for (int i = 0; i < 7; i++) begin
         nxt = (i < 6) ? v[i+1] : 16'hA5A5;
         cap(31, nxt, w0, w1, ok);
         e0 = {v[i] ^ 16'h8000, v[i] ^ 16'h8000};
         e1 = {v[i], v[i]};
         checks++;
         if (!ok || w0 !== e0) begin failures++; $display("FAIL conv_u0 in=%h got=%h exp=%h", v[i], w0, e0); end
         checks++;
         if (!ok || w1 !== e1) begin failures++; $display("FAIL conv_u1 in=%h got=%h exp=%h", v[i], w1, e1); end
      end
   endtask

   task automatic test_midframe;
      logic [31:0] w0, w1; bit ok;
      cap(8, 16'h3C3C, w0, w1, ok);
      checks++;
      if (!ok || w0 !== 32'h25A525A5) begin failures++; $display("FAIL mid_cur got=%h exp=25a525a5", w0); end
      cap(31, 16'h3C3C, w0, w1, ok);
      checks++;
      if (!ok || w0 !== 32'hBC3CBC3C) begin failures++; $display("FAIL mid_next got=%h exp=bc3cbc3c", w0); end
   endtask

   task automatic test_drain;
      int k = 0;
      repeat (20*D) @(negedge clk);
      enable = 1'b0;
      while (busy_o === 1'b1 && k < 200) begin @(negedge clk); k++; end
      checks++;
      if (k != 44*D) begin failures++; $display("FAIL drain_len cycles=%0d exp=%0d", k, 44*D); end
      checks++;
      if ({bclk_o, lrclk_o, sdata_o, frame_o, busy_o} !== 5'b0) begin
         failures++; $display("FAIL drain_idle got=%b exp=00000", {bclk_o, lrclk_o, sdata_o, frame_o, busy_o});
      end
      enable = 1'b1; k = 0;
      do begin @(negedge clk); k++; end while (frame_o !== 1'b1 && k < 50);
      checks++;
      if (k != 2*D + 1) begin failures++; $display("FAIL restart_frame negedges=%0d exp=%0d", k, 2*D + 1); end
      repeat (20*D) @(negedge clk);
      enable = 1'b0;
      repeat (20*D) @(negedge clk);
      checks++;
      if (busy_o !== 1'b1) begin failures++; $display("FAIL drain_busy busy=%b exp=1", busy_o); end
      enable = 1'b1; k = 0;
      do begin @(negedge clk); k++; end while (frame_o !== 1'b1 && k < 200);
      checks++;
      if (k != 24*D) begin failures++; $display("FAIL reenable_gap negedges=%0d exp=%0d", k, 24*D); end
   endtask

   task automatic test_reset_mid;
      int k = 0; logic [31:0] w0, w1; bit ok;
      repeat (40*D) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if ({bclk_o, lrclk_o, sdata_o, frame_o, busy_o, bclk1, lr1, sd1, fr1, busy1} !== 10'b0) begin
         failures++;
         $display("FAIL reset_mid got=%b exp=0000000000",
                  {bclk_o, lrclk_o, sdata_o, frame_o, busy_o, bclk1, lr1, sd1, fr1, busy1});
      end
      rst = 1'b0;
      do begin @(negedge clk); k++; end while (frame_o !== 1'b1 && k < 50);
      checks++;
      if (k != 2*D + 1) begin failures++; $display("FAIL reset_restart negedges=%0d exp=%0d", k, 2*D + 1); end
      cap(31, 16'h3C3C, w0, w1, ok);
      checks++;
      if (!ok || w1 !== 32'h3C3C3C3C) begin failures++; $display("FAIL reset_word got=%h exp=3c3c3c3c", w1); end
      enable = 1'b0;
   endtask

   initial begin
      test_reset;
      test_basic;
      test_bounds;
      test_midframe;
      test_drain;
      test_reset_mid;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/apu_i2s_tx.md
APU_I2S_TX -- requirements
Module: apu_i2s_tx

Interface
REQ-001 SHALL have parameter BCLK_DIV, default 4: clk_i cycles per BCLK half-period; legal range 1..255.
REQ-002 SHALL have parameter UNSIGNED_IN, default 1: when 1, sample_i is offset-binary and is converted to two's complement by inverting bit 15.
REQ-003 SHALL have port clk_i, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port sample_i, input, 16 bits: mixed mono audio from wb_apu audio_o, sampled once per frame.
REQ-006 SHALL have port enable_i, input, 1 bit: run request (level).
REQ-007 SHALL have port bclk_o, output, 1 bit: I2S bit clock.
REQ-008 SHALL have port lrclk_o, output, 1 bit: I2S word select; 0 means left, 1 means right.
REQ-009 SHALL have port sdata_o, output, 1 bit: I2S serial data, MSB first.
REQ-010 SHALL have port frame_o, output, 1 bit: one-clk_i pulse on each sample latch.
REQ-011 SHALL have port busy_o, output, 1 bit: high in RUN and DRAIN.

Function
REQ-012 SHALL implement states IDLE, RUN and DRAIN.
REQ-013 SHALL make these state transitions: IDLE->RUN when enable_i=1; RUN->DRAIN when enable_i=0; DRAIN->RUN when enable_i=1 again; DRAIN->IDLE at the end of bit slot 31.
REQ-014 SHALL, in IDLE, hold bclk_o, lrclk_o, sdata_o, frame_o and busy_o at 0, with div_cnt=0 and bit_cnt=31.
REQ-015 SHALL, outside IDLE, increment an 8-bit div_cnt each clk_i cycle, toggle bclk_o and clear div_cnt when div_cnt = BCLK_DIV-1, so the BCLK period is 2*BCLK_DIV clk_i cycles.
REQ-016 SHALL treat a toggle that drives bclk_o 1->0 as a falling edge; on each falling edge bit_cnt increments mod 32 (31 wraps to 0), and sdata_o/lrclk_o update on that same clk_i edge.
REQ-017 SHALL, on the falling edge where bit_cnt wraps 31->0: latch the converted sample_i into a 32-bit shift register as {s,s}, drive sdata_o with bit 31 of the register, and pulse frame_o for exactly one clk_i cycle.
REQ-018 SHALL, on every other falling edge, shift the register left by 1 and drive sdata_o with the new bit 31; the left slot is bit_cnt 0..15 and carries s[15-n], the right slot is bit_cnt 16..31 and carries s[31-n].
REQ-019 SHALL drive lrclk_o to 1 for bit_cnt 15..30 and to 0 for bit_cnt 31 and 0..14, giving the standard I2S one-bit lead.
REQ-020 SHALL produce its first falling edge, and therefore its first frame_o, exactly 2*BCLK_DIV clk_i cycles after the clk_i edge on which IDLE->RUN is taken.
REQ-021 SHALL take a new sample only at a frame boundary; sample_i changes mid-frame SHALL NOT affect the frame currently being sent.
REQ-022 SHALL, in DRAIN, keep clocking until bit slot 31 completes, meaning the falling edge that would wrap bit_cnt is reached; on that edge it enters IDLE with all outputs 0, and no frame_o pulse or latch occurs.
REQ-023 SHALL ignore enable_i pulses shorter than one clk_i cycle; no further glitch handling is required.
REQ-024 SHALL NOT let outputs depend combinationally on inputs; every output is registered.

Reset
REQ-025 SHALL, with rst_i=1 at a clk_i edge, force IDLE, div_cnt=0, bit_cnt=31, shift register=0 and all outputs=0, regardless of the current state, including mid-frame.
REQ-026 SHALL, after rst_i is released with enable_i=1, behave as a fresh IDLE->RUN transition per REQ-020.

Verification
REQ-027 SHALL cover basic frame: BCLK_DIV=2, UNSIGNED_IN=1, sample_i=0xC000, enable from IDLE -> frame_o at clk 4; bclk period 4 clk; left=right=0x4000 serialized MSB first; next frame_o 128 clk later.
REQ-028 SHALL cover conversion bounds: sample_i=0xFFFF -> 0x7FFF on both channels; sample_i=0x0000 -> 0x8000; with UNSIGNED_IN=0, sample_i=0x1234 -> 0x1234.
REQ-029 SHALL cover LRCLK alignment: check lrclk_o rises on the falling edge of bit_cnt 15 and falls on bit_cnt 31, each one BCLK before the channel MSB.
REQ-030 SHALL cover mid-frame sample change: change sample_i at bit_cnt 8 -> current frame unchanged; new value appears in the next frame only.
REQ-031 SHALL cover disable/drain: drop enable_i at bit_cnt 10 -> busy_o stays 1 through slot 31, then all outputs 0; re-assert during DRAIN -> continuous frames with no gap.
REQ-032 SHALL cover reset mid-frame: assert rst_i at bit_cnt 20 -> next clk all outputs 0, state IDLE; after release with enable_i=1, frame_o occurs 2*BCLK_DIV clk later.
